// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code types and conversion helpers
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } gray_state_e;

   localparam int GRAY_MAX_W = 32;

   // Operands are zero-extended, so the conversions hold for any width up to GRAY_MAX_W.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = g;
      for (int k = 1; k < GRAY_MAX_W; k++) begin
         b = b ^ (g >> k);
      end
      return b;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray-to-binary XOR prefix chain
module gray_to_bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   always_comb begin
      bin_o[WIDTH-1] = gray_i[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         bin_o[i] = bin_o[i+1] ^ gray_i[i];
      end
   end

endmodule

// File: rtl/gray_code_decoder.sv
// rtl/gray_code_decoder.sv - Gray bus decoder with step check and lock FSM
// Optional error counter: GRAY_DEC_ERR_CNT_EN
module gray_code_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int RELOCK = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   gray_state_e      state_q, state_d;
   logic [3:0]       gcnt_q, gcnt_d;
   logic [4:0]       gcnt_inc;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] bin_new;
   logic [WIDTH-1:0] delta;
   logic             legal;
   logic             valid_q, valid_d;
   logic             step_err_q, step_err_d;

   gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
      .gray_i (gray_in),
      .bin_o  (bin_new)
   );

   // bin_q doubles as the previous-sample reference and the bin_out register.
   assign delta    = bin_new - bin_q;
   assign legal    = (delta == '0) || (delta == WIDTH'(1));
   assign gcnt_inc = {1'b0, gcnt_q} + 5'd1;

   always_comb begin
      state_d    = state_q;
      gcnt_d     = gcnt_q;
      bin_d      = bin_q;
      valid_d    = 1'b0;
      step_err_d = 1'b0;
      if (en) begin
         bin_d   = bin_new;
         valid_d = 1'b1;
         case (state_q)
            IDLE: begin
               gcnt_d  = '0;
               state_d = ACQUIRE;
            end
            ACQUIRE: begin
               if (legal) begin
                  gcnt_d = gcnt_inc[3:0];
                  if (gcnt_inc >= 5'(RELOCK)) begin
                     state_d = LOCKED;
                  end
               end else begin
                  step_err_d = 1'b1;
                  gcnt_d     = '0;
               end
            end
            LOCKED: begin
               if (!legal) begin
                  step_err_d = 1'b1;
                  gcnt_d     = '0;
                  state_d    = ACQUIRE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gcnt_q     <= '0;
         bin_q      <= '0;
         valid_q    <= 1'b0;
         step_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gcnt_q     <= gcnt_d;
         bin_q      <= bin_d;
         valid_q    <= valid_d;
         step_err_q <= step_err_d;
      end
   end

   assign bin_out   = bin_q;
   assign bin_valid = valid_q;
   assign step_err  = step_err_q;
   assign locked    = (state_q == LOCKED);

`ifdef GRAY_DEC_ERR_CNT_EN
   logic [ERR_W-1:0] err_cnt_q;

   // Only errors that break an established lock are counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (step_err_d && (state_q == LOCKED) && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_gray_code_decoder.sv
// tb/tb_gray_code_decoder.sv - table-driven scoreboard bench for gray_code_decoder
module tb_gray_code_decoder;

   localparam int WIDTH  = 4;
   localparam int RELOCK = 2;
   localparam int ERR_W  = 2;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] gray_in;
   logic [WIDTH-1:0] bin_out;
   logic             bin_valid;
   logic             step_err;
   logic             locked;
   logic [ERR_W-1:0] err_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       en;
      logic [3:0] gray;
      logic [3:0] bin;
      logic       valid;
      logic       err;
      logic       lock;
      logic [1:0] cnt;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   gray_code_decoder #(
      .WIDTH  (WIDTH),
      .RELOCK (RELOCK),
      .ERR_W  (ERR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .gray_in   (gray_in),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .step_err  (step_err),
      .locked    (locked),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [1:0] exp_cnt(input logic [1:0] c);
`ifdef GRAY_DEC_ERR_CNT_EN
      return c;
`else
      return 2'd0 & c;
`endif
   endfunction

   task automatic compare(input string tag, input vec_t e);
      check({tag, " bin_out"},   int'(bin_out),   int'(e.bin));
      check({tag, " bin_valid"}, int'(bin_valid), int'(e.valid));
      check({tag, " step_err"},  int'(step_err),  int'(e.err));
      check({tag, " locked"},    int'(locked),    int'(e.lock));
      check({tag, " err_count"}, int'(err_count), int'(exp_cnt(e.cnt)));
   endtask

   task automatic drive(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      en      = v.en;
      gray_in = v.gray;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare($sformatf("v%0d", idx), e);
   endtask

   task automatic add(input logic e, input logic [3:0] g, input logic [3:0] b,
                      input logic v, input logic er, input logic l, input logic [1:0] c);
      vec_t t;
      t.en = e; t.gray = g; t.bin = b; t.valid = v; t.err = er; t.lock = l; t.cnt = c;
      vecs.push_back(t);
   endtask

   initial begin
      vec_t z;
      rst_n   = 1'b0;
      en      = 1'b0;
      gray_in = '0;

      // monotonic start, skip, wrap while locked, backward, hold, gap, saturation
      add(1, 4'b0000, 4'd0,  1, 0, 0, 0);
      add(1, 4'b0001, 4'd1,  1, 0, 0, 0);
      add(1, 4'b0011, 4'd2,  1, 0, 1, 0);
      add(1, 4'b0010, 4'd3,  1, 0, 1, 0);
      add(1, 4'b0111, 4'd5,  1, 1, 0, 1);
      add(1, 4'b0101, 4'd6,  1, 0, 0, 1);
      add(1, 4'b0100, 4'd7,  1, 0, 1, 1);
      add(1, 4'b1010, 4'd12, 1, 1, 0, 2);
      add(1, 4'b1011, 4'd13, 1, 0, 0, 2);
      add(1, 4'b1001, 4'd14, 1, 0, 1, 2);
      add(1, 4'b1000, 4'd15, 1, 0, 1, 2);
      add(1, 4'b0000, 4'd0,  1, 0, 1, 2);
      add(1, 4'b0001, 4'd1,  1, 0, 1, 2);
      add(1, 4'b0011, 4'd2,  1, 0, 1, 2);
      add(1, 4'b0010, 4'd3,  1, 0, 1, 2);
      add(1, 4'b0011, 4'd2,  1, 1, 0, 3);
      add(1, 4'b0110, 4'd4,  1, 1, 0, 3);
      add(1, 4'b0110, 4'd4,  1, 0, 0, 3);
      add(1, 4'b0110, 4'd4,  1, 0, 1, 3);
      add(0, 4'b1111, 4'd4,  0, 0, 1, 3);
      add(0, 4'b1111, 4'd4,  0, 0, 1, 3);
      add(0, 4'b1111, 4'd4,  0, 0, 1, 3);
      add(1, 4'b0111, 4'd5,  1, 0, 1, 3);
      add(1, 4'b0000, 4'd0,  1, 1, 0, 3);
      add(1, 4'b0001, 4'd1,  1, 0, 0, 3);
      add(1, 4'b0011, 4'd2,  1, 0, 1, 3);
      add(1, 4'b0111, 4'd5,  1, 1, 0, 3);
      add(1, 4'b0101, 4'd6,  1, 0, 0, 3);
      add(1, 4'b0100, 4'd7,  1, 0, 1, 3);

      z.en = 0; z.gray = 0; z.bin = 0; z.valid = 0; z.err = 0; z.lock = 0; z.cnt = 0;

      repeat (2) @(posedge clk);
      #1;
      compare("reset", z);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i], i);
      end

      // asynchronous reset between edges while locked with a saturated counter
      #2;
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      compare("midrst", z);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      compare("postrst_idle", z);

      vecs.delete();
      add(1, 4'b0101, 4'd6, 1, 0, 0, 0);
      add(1, 4'b0100, 4'd7, 1, 0, 0, 0);
      add(1, 4'b1100, 4'd8, 1, 0, 1, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i], 100 + i);
      end

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
